processador: RTL and testbench
==============================

// Module: processador
// PURPOSE
//  Multi-cycle 16-bit accumulator-less CPU: 8 registers (R7 = PC), 10-bit instruction fetched from memory.
//  Connects to synchronous-read memory (1-cycle read latency) through ADDR/DOUT/W/DIN.
//  Register/IR/PC snapshots are exported for 7-segment debug displays at board top level.
// PARAMETERS
//  RESET_PC  16'h0000  value loaded into R7 (PC) on reset
// PORTS
//  Clock      in   1   single system clock, rising edge
//  Resetn     in   1   asynchronous, active-low reset
//  Run        in   1   1 = FSM advances; 0 = all state frozen (stall)
//  DIN        in   16  memory read data (valid 1 cycle after ADDR update)
//  Done       out  1   1-cycle pulse in last execute cycle of each instruction
//  W          out  1   registered memory write enable
//  ADDR       out  16  registered memory address
//  DOUT       out  16  registered memory write data
//  instrucao  out  10  current IR
//  R0..R5     out  16  each: register contents (6 ports)
//  PC         out  16  R7 contents
// BEHAVIOUR
//  Reset (async, Resetn=0): R0-R6=0, R7=RESET_PC, IR=0, ADDR=0, DOUT=0, W=0, Done=0, NZ flag=0, state=F0.
//  Run=0: no register/state changes; W forced 0 for the stalled cycle. Resumes exactly where it stopped.
//  IR format: op=IR[9:6], rX=IR[5:3], rY=IR[2:0]; IR loaded from DIN[9:0].
//  Fetch: F0 ADDR<=R7, R7<=R7+1 -> F1 wait -> F2 IR<=DIN[9:0] -> E1.
//  Opcodes (execute states; Done asserted in the final one, then -> F0):
//   0000 ld  rX,[rY]: E1 ADDR<=rY; E2 wait; E3 rX<=DIN.
//   0001 st  rX,[rY]: E1 ADDR<=rY, DOUT<=rX, W<=1; E2 W<=0.
//   0010 mvnz rX,rY:  E1 if NZ==1 rX<=rY.
//   0011 mv  rX,rY:   E1 rX<=rY.
//   0100 mvi rX,#D:   E1 ADDR<=R7, R7<=R7+1; E2 wait; E3 rX<=DIN (D = next word).
//   0101 add / 0110 sub / 0111 or / 1000 slt (signed, result 1/0) / 1001 sll / 1010 srl:
//        E1 A<=rX; E2 G<=A op rY, NZ<=(result!=0); E3 rX<=G.
//   1011-1111: NOP, Done in E1.
//  Arithmetic mod 2^16, no carry/overflow outputs; shift amount = rY[3:0], zero fill.
//  rX=R7 legal: write overrides PC increment (jump). If rX==rY, operand is read before write.
//  W high exactly one cycle per st (unless Run drops, then the write is retried at resume).
//  Done never asserted during fetch; back-to-back instructions: Done then F0 next cycle.
//  Reset mid-instruction aborts it; no partial write beyond the already-issued W cycle.
// STRUCTURE
//  Shared package: opcode localparams, FSM state enum (F0,F1,F2,E1,E2,E3), IR field widths.
//  One sub-module: processador_alu (A, B, op -> G, nz), purely combinational.
//  Register file, PC, IR, FSM stay in processador. Memory and display decoders are separate blocks.
// TESTING
//  Reset: Resetn=0 mid-execute -> all outputs 0, PC=0; after release and Run=1, ADDR=0 in first cycle.
//  mvi R0,#5; mvi R1,#3; add R0,R1 -> R0=8, R1=3, NZ=1; Done pulses 3 times; PC=5.
//  sub R2,R2 (R2=7) -> R2=0, NZ=0; following mvnz R3,R1 leaves R3 unchanged.
//  st R0,[R1] with R0=16'hABCD, R1=16'h0020 -> W=1 one cycle, ADDR=0x20, DOUT=0xABCD; ld R4,[R1] -> R4=0xABCD.
//  Loop: mvi R5,#3; body sub R5,R6(=1); mvnz R7,R4 -> body runs 3 times, exits with R5=0.
//  Run toggled 0 for 5 cycles mid-add -> result and PC identical to uninterrupted run; no extra Done/W.

Source files
------------

// File: rtl/processador_pkg.sv
// Shared definitions for the multi-cycle processor: field widths, opcodes,
// FSM states and the per-opcode final execute state.
package processador_pkg;

    localparam int DATA_W = 16;
    localparam int IR_W   = 10;
    localparam int OP_W   = 4;
    localparam int REG_W  = 3;

    localparam logic [OP_W-1:0] OP_LD   = 4'b0000;
    localparam logic [OP_W-1:0] OP_ST   = 4'b0001;
    localparam logic [OP_W-1:0] OP_MVNZ = 4'b0010;
    localparam logic [OP_W-1:0] OP_MV   = 4'b0011;
    localparam logic [OP_W-1:0] OP_MVI  = 4'b0100;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0101;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0110;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0111;
    localparam logic [OP_W-1:0] OP_SLT  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SLL  = 4'b1001;
    localparam logic [OP_W-1:0] OP_SRL  = 4'b1010;

    typedef enum logic [2:0] {F0, F1, F2, E1, E2, E3} state_t;

    // Execute state in which an instruction completes and Done is shown.
    function automatic state_t last_exec(input logic [OP_W-1:0] op);
        state_t s;
        case (op)
            OP_LD, OP_MVI, OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SRL: s = E3;
            OP_ST:   s = E2;
            default: s = E1;
        endcase
        last_exec = s;
    endfunction

endpackage

// File: rtl/processador_alu.sv
// Combinational ALU: add/sub/or/signed-less-than/logical shifts, plus a
// non-zero flag for the conditional move.
module processador_alu
    import processador_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] g,
    output logic              nz
);

    always_comb begin
        g = '0;
        case (op)
            OP_ADD:  g = a + b;
            OP_SUB:  g = a - b;
            OP_OR:   g = a | b;
            OP_SLT:  g = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  g = a << b[3:0];
            OP_SRL:  g = a >> b[3:0];
            default: g = '0;
        endcase
        nz = (g != '0);
    end

endmodule

// File: rtl/processador.sv
// Multi-cycle 16-bit CPU with 8 registers (R7 is the PC) talking to a
// synchronous-read memory; register snapshots are exported for debug.
module processador
    import processador_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              Done,
    output logic              W,
    output logic [DATA_W-1:0] ADDR,
    output logic [DATA_W-1:0] DOUT,
    output logic [IR_W-1:0]   instrucao,
    output logic [DATA_W-1:0] R0,
    output logic [DATA_W-1:0] R1,
    output logic [DATA_W-1:0] R2,
    output logic [DATA_W-1:0] R3,
    output logic [DATA_W-1:0] R4,
    output logic [DATA_W-1:0] R5,
    output logic [DATA_W-1:0] PC
);

    logic [DATA_W-1:0] regs_reg [0:7];
    logic [IR_W-1:0]   ir_reg;
    logic [DATA_W-1:0] addr_reg, dout_reg, a_reg, g_reg;
    logic              w_reg, done_reg, nz_reg;
    state_t            state_reg;

    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rx, ry;
    logic [DATA_W-1:0] rx_val, ry_val, pc_val, alu_g;
    logic              alu_nz;
    state_t            last_st, exec_next;

    assign op      = ir_reg[IR_W-1 -: OP_W];
    assign rx      = ir_reg[2*REG_W-1 -: REG_W];
    assign ry      = ir_reg[REG_W-1:0];
    assign rx_val  = regs_reg[rx];
    assign ry_val  = regs_reg[ry];
    assign pc_val  = regs_reg[7];
    assign last_st = last_exec(op);

    always_comb begin
        exec_next = E3;
        if (state_reg == E1)
            exec_next = E2;
    end

    processador_alu u_alu (
        .a  (a_reg),
        .b  (ry_val),
        .op (op),
        .g  (alu_g),
        .nz (alu_nz)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < 7; i++)
                regs_reg[i] <= '0;
            regs_reg[7] <= RESET_PC;
            ir_reg      <= '0;
            addr_reg    <= '0;
            dout_reg    <= '0;
            a_reg       <= '0;
            g_reg       <= '0;
            w_reg       <= 1'b0;
            done_reg    <= 1'b0;
            nz_reg      <= 1'b0;
            state_reg   <= F0;
        end else if (Run) begin
            case (state_reg)
                F0: begin
                    addr_reg    <= pc_val;
                    regs_reg[7] <= pc_val + 1'b1;
                    state_reg   <= F1;
                end
                F1: state_reg <= F2;
                F2: begin
                    ir_reg    <= DIN[IR_W-1:0];
                    // Done is registered, so it is armed on entry to the final state.
                    done_reg  <= (last_exec(DIN[IR_W-1 -: OP_W]) == E1);
                    state_reg <= E1;
                end
                default: begin
                    if (state_reg == last_st) begin
                        state_reg <= F0;
                        done_reg  <= 1'b0;
                    end else begin
                        state_reg <= exec_next;
                        done_reg  <= (exec_next == last_st);
                    end
                    case (op)
                        OP_LD: begin
                            if (state_reg == E1)
                                addr_reg <= ry_val;
                            else if (state_reg == E3)
                                regs_reg[rx] <= DIN;
                        end
                        OP_ST: begin
                            if (state_reg == E1) begin
                                addr_reg <= ry_val;
                                dout_reg <= rx_val;
                                w_reg    <= 1'b1;
                            end else begin
                                w_reg    <= 1'b0;
                            end
                        end
                        OP_MVNZ: if (nz_reg) regs_reg[rx] <= ry_val;
                        OP_MV:   regs_reg[rx] <= ry_val;
                        OP_MVI: begin
                            if (state_reg == E1) begin
                                addr_reg    <= pc_val;
                                regs_reg[7] <= pc_val + 1'b1;
                            end else if (state_reg == E3) begin
                                regs_reg[rx] <= DIN;
                            end
                        end
                        OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SRL: begin
                            case (state_reg)
                                E1: a_reg <= rx_val;
                                E2: begin
                                    g_reg  <= alu_g;
                                    nz_reg <= alu_nz;
                                end
                                default: regs_reg[rx] <= g_reg;
                            endcase
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    // Stalled cycles must not be seen as a write or a completion by the memory/board.
    assign W         = w_reg & Run;
    assign Done      = done_reg & Run;
    assign ADDR      = addr_reg;
    assign DOUT      = dout_reg;
    assign instrucao = ir_reg;
    assign R0        = regs_reg[0];
    assign R1        = regs_reg[1];
    assign R2        = regs_reg[2];
    assign R3        = regs_reg[3];
    assign R4        = regs_reg[4];
    assign R5        = regs_reg[5];
    assign PC        = regs_reg[7];

endmodule

// File: tb/tb_processador.sv
// Bench for processador: 256-word synchronous memory, ALU vector table,
// directed multi-cycle sequences and random programs against an ISA model.
module tb_processador;

    logic        Clock = 1'b0;
    logic        Resetn, Run;
    logic [15:0] DIN;
    logic        Done, W;
    logic [15:0] ADDR, DOUT;
    logic [9:0]  instrucao;
    logic [15:0] R0, R1, R2, R3, R4, R5, PC;

    always #5 Clock = ~Clock;

    processador #(.RESET_PC(16'h0000)) dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN),
        .Done(Done), .W(W), .ADDR(ADDR), .DOUT(DOUT), .instrucao(instrucao),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .PC(PC)
    );

    // Memory with a load port used only while the CPU is held in reset.
    logic [15:0] mem [0:255];
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    always @(posedge Clock) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (W)
            mem[ADDR[7:0]] <= DOUT;
        DIN <= mem[ADDR[7:0]];
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] prog [0:255];
    int          plen;
    logic [15:0] mr [0:7];
    logic [15:0] mm [0:255];
    logic        mnz;
    logic [15:0] w_addr, w_data;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] g;
        logic        nz;
    } alu_vec_t;
    alu_vec_t vecs [12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry);
        return {6'b0, op, rx, ry};
    endfunction

    function automatic logic [127:0] dut_regs();
        return {R0, R1, R2, R3, R4, R5, PC, 16'h0000};
    endfunction

    function automatic logic [127:0] model_regs();
        return {mr[0], mr[1], mr[2], mr[3], mr[4], mr[5], mr[7], 16'h0000};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
        plen = 0;
    endtask

    task automatic put(input logic [15:0] word);
        prog[plen] = word;
        plen++;
    endtask

    // Hold reset, load memory and model, release reset at a falling edge.
    task automatic start();
        Resetn = 1'b0;
        Run    = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ld_addr = 8'(i);
            ld_data = prog[i];
            ld_en   = 1'b1;
            mm[i]   = prog[i];
            @(negedge Clock);
        end
        ld_en = 1'b0;
        for (int i = 0; i < 8; i++) mr[i] = 16'h0000;
        mnz    = 1'b0;
        Resetn = 1'b1;
    endtask

    // Run until n Done pulses, let the final write land, then freeze in F0.
    task automatic run_instrs(input int n, output int cyc, output int dn, output int wn);
        cyc = 0; dn = 0; wn = 0;
        Run = 1'b1;
        while (dn < n && cyc < 50 * n + 20) begin
            @(negedge Clock);
            cyc++;
            if (Done) dn++;
            if (W) begin
                wn++;
                w_addr = ADDR;
                w_data = DOUT;
            end
        end
        if (dn < n) check("done_timeout", 128'(dn), 128'(n));
        @(negedge Clock);
        cyc++;
        Run = 1'b0;
    endtask

    // Instruction-level reference: one whole instruction per call.
    task automatic model_step(output int cyc);
        logic [15:0] iw, x, y, d;
        logic [3:0]  op;
        logic [2:0]  rx, ry;
        iw    = mm[mr[7][7:0]];
        mr[7] = mr[7] + 16'd1;
        op = iw[9:6]; rx = iw[5:3]; ry = iw[2:0];
        x = mr[rx]; y = mr[ry];
        cyc = 4;
        case (op)
            4'h0: begin mr[rx] = mm[y[7:0]]; cyc = 6; end
            4'h1: begin mm[y[7:0]] = x; cyc = 5; end
            4'h2: if (mnz) mr[rx] = y;
            4'h3: mr[rx] = y;
            4'h4: begin
                d = mm[mr[7][7:0]];
                mr[7] = mr[7] + 16'd1;
                mr[rx] = d;
                cyc = 6;
            end
            4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
                case (op)
                    4'h5:    d = x + y;
                    4'h6:    d = x - y;
                    4'h7:    d = x | y;
                    4'h8:    d = ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
                    4'h9:    d = x << y[3:0];
                    default: d = x >> y[3:0];
                endcase
                mnz = (d != 16'h0000);
                mr[rx] = d;
                cyc = 6;
            end
            default: ;
        endcase
    endtask

    initial begin
        int cyc, dn, wn, mc, msum, wcount;
        Resetn = 1'b0; Run = 1'b0;
        ld_en = 1'b0; ld_addr = 8'h00; ld_data = 16'h0000;
        @(negedge Clock);

        vecs[0]  = '{4'h5, 16'hFFFF, 16'h0002, 16'h0001, 1'b1};
        vecs[1]  = '{4'h5, 16'h8000, 16'h8000, 16'h0000, 1'b0};
        vecs[2]  = '{4'h6, 16'h0003, 16'h0005, 16'hFFFE, 1'b1};
        vecs[3]  = '{4'h7, 16'h00F0, 16'h0F0F, 16'h0FFF, 1'b1};
        vecs[4]  = '{4'h8, 16'hFFFF, 16'h0001, 16'h0001, 1'b1};
        vecs[5]  = '{4'h8, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
        vecs[6]  = '{4'h8, 16'h8000, 16'h7FFF, 16'h0001, 1'b1};
        vecs[7]  = '{4'h9, 16'h0001, 16'h0013, 16'h0008, 1'b1};
        vecs[8]  = '{4'h9, 16'h8001, 16'h000F, 16'h8000, 1'b1};
        vecs[9]  = '{4'hA, 16'h8000, 16'h0010, 16'h8000, 1'b1};
        vecs[10] = '{4'hA, 16'hF000, 16'h0004, 16'h0F00, 1'b1};
        vecs[11] = '{4'hB, 16'h1234, 16'h5678, 16'h1234, 1'b0};

        // Reset in the middle of an add.
        clear_prog();
        put(enc(4'h4, 3'd0, 3'd0)); put(16'h0005);
        put(enc(4'h4, 3'd1, 3'd0)); put(16'h0003);
        put(enc(4'h5, 3'd0, 3'd1));
        start();
        run_instrs(2, cyc, dn, wn);
        check("pre_reset_r0", 128'(R0), 128'(16'h0005));
        Run = 1'b1;
        repeat (4) @(negedge Clock);
        Resetn = 1'b0;
        #1;
        check("reset_regs", dut_regs(), 128'h0);
        check("reset_addr_dout", {ADDR, DOUT}, 128'h0);
        check("reset_ir", 128'(instrucao), 128'h0);
        check("reset_w_done", {W, Done}, 128'h0);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        check("post_reset_addr", 128'(ADDR), 128'h0);
        check("post_reset_pc", 128'(PC), 128'h1);
        Run = 1'b0;
        $display("reset mid-execute: R0=%h PC=%h ADDR=%h", R0, PC, ADDR);

        // ALU vector table.
        for (int v = 0; v < 12; v++) begin
            clear_prog();
            put(enc(4'h4, 3'd0, 3'd0)); put(vecs[v].a);
            put(enc(4'h4, 3'd1, 3'd0)); put(vecs[v].b);
            put(enc(4'h4, 3'd3, 3'd0)); put(16'h0001);
            put(enc(vecs[v].op, 3'd0, 3'd1));
            put(enc(4'h2, 3'd2, 3'd3));
            start();
            run_instrs(5, cyc, dn, wn);
            check($sformatf("alu%0d_g", v), 128'(R0), 128'(vecs[v].g));
            check($sformatf("alu%0d_nz", v), 128'(R2), 128'({15'b0, vecs[v].nz}));
            $display("alu vec %0d op=%h a=%h b=%h -> g=%h nz=%0d", v, vecs[v].op, vecs[v].a, vecs[v].b, R0, R2[0]);
        end

        // mvi/mvi/add then mvnz observing NZ=1.
        clear_prog();
        put(enc(4'h4, 3'd0, 3'd0)); put(16'h0005);
        put(enc(4'h4, 3'd1, 3'd0)); put(16'h0003);
        put(enc(4'h5, 3'd0, 3'd1));
        put(enc(4'h2, 3'd2, 3'd0));
        start();
        run_instrs(3, cyc, dn, wn);
        check("add_r0_r1", {R0, R1}, {16'h0008, 16'h0003});
        check("add_pc", 128'(PC), 128'h5);
        check("add_done_pulses", 128'(dn), 128'd3);
        check("add_cycles", 128'(cyc), 128'd18);
        run_instrs(1, cyc, dn, wn);
        check("add_nz_mvnz", 128'(R2), 128'h8);
        $display("add seq: R0=%h R1=%h R2=%h PC=%h", R0, R1, R2, PC);

        // sub to zero clears NZ, mvnz must not move.
        clear_prog();
        put(enc(4'h4, 3'd1, 3'd0)); put(16'h0004);
        put(enc(4'h4, 3'd2, 3'd0)); put(16'h0007);
        put(enc(4'h4, 3'd3, 3'd0)); put(16'h0009);
        put(enc(4'h6, 3'd2, 3'd2));
        put(enc(4'h2, 3'd3, 3'd1));
        start();
        run_instrs(4, cyc, dn, wn);
        check("sub_self_r2", 128'(R2), 128'h0);
        run_instrs(1, cyc, dn, wn);
        check("mvnz_blocked_r3", 128'(R3), 128'h9);
        $display("sub seq: R2=%h R3=%h", R2, R3);

        // Store then load through the same pointer.
        clear_prog();
        put(enc(4'h4, 3'd0, 3'd0)); put(16'hABCD);
        put(enc(4'h4, 3'd1, 3'd0)); put(16'h0020);
        put(enc(4'h1, 3'd0, 3'd1));
        put(enc(4'h0, 3'd4, 3'd1));
        start();
        run_instrs(3, cyc, dn, wn);
        check("st_w_cycles", 128'(wn), 128'd1);
        check("st_addr_dout", {w_addr, w_data}, {16'h0020, 16'hABCD});
        check("st_cycles", 128'(cyc), 128'd17);
        run_instrs(1, cyc, dn, wn);
        check("ld_r4", 128'(R4), 128'hABCD);
        check("st_mem", 128'(mem[8'h20]), 128'hABCD);
        $display("st/ld seq: R4=%h mem[20]=%h", R4, mem[8'h20]);

        // Count-down loop using mvnz into R7.
        clear_prog();
        put(enc(4'h4, 3'd5, 3'd0)); put(16'h0003);
        put(enc(4'h4, 3'd6, 3'd0)); put(16'h0001);
        put(enc(4'h4, 3'd4, 3'd0)); put(16'h0006);
        put(enc(4'h5, 3'd3, 3'd6));
        put(enc(4'h6, 3'd5, 3'd6));
        put(enc(4'h2, 3'd7, 3'd4));
        start();
        msum = 0;
        for (int k = 0; k < 12; k++) begin model_step(mc); msum += mc; end
        run_instrs(12, cyc, dn, wn);
        check("loop_r5_r3", {R5, R3}, {16'h0000, 16'h0003});
        check("loop_pc", 128'(PC), 128'h9);
        check("loop_model", dut_regs(), model_regs());
        check("loop_cycles", 128'(cyc), 128'(msum));
        $display("loop seq: R3=%h R5=%h PC=%h cycles=%0d", R3, R5, PC, cyc);

        // Stall for 5 cycles inside add.
        clear_prog();
        put(enc(4'h4, 3'd0, 3'd0)); put(16'h0005);
        put(enc(4'h4, 3'd1, 3'd0)); put(16'h0003);
        put(enc(4'h5, 3'd0, 3'd1));
        start();
        run_instrs(2, cyc, dn, wn);
        wcount = 0;
        Run = 1'b1;
        repeat (3) begin
            @(negedge Clock);
            wcount += int'(Done) + int'(W);
        end
        Run = 1'b0;
        repeat (5) begin
            @(negedge Clock);
            wcount += int'(Done) + int'(W);
        end
        check("stall_no_done_w", 128'(wcount), 128'd0);
        run_instrs(1, cyc, dn, wn);
        check("stall_resume_cycles", 128'(cyc), 128'd3);
        check("stall_r0_pc", {R0, PC}, {16'h0008, 16'h0005});
        check("stall_done_once", 128'(dn), 128'd1);
        $display("stall seq: R0=%h PC=%h", R0, PC);

        // Stall on the store's write cycle: the write must be retried.
        clear_prog();
        put(enc(4'h4, 3'd0, 3'd0)); put(16'hBEEF);
        put(enc(4'h4, 3'd1, 3'd0)); put(16'h0030);
        put(enc(4'h1, 3'd0, 3'd1));
        start();
        run_instrs(2, cyc, dn, wn);
        Run = 1'b1;
        repeat (4) @(negedge Clock);
        check("st_stall_w_before", {W, ADDR, DOUT}, {1'b1, 16'h0030, 16'hBEEF});
        Run = 1'b0;
        wcount = 0;
        repeat (3) begin
            @(negedge Clock);
            wcount += int'(W) + int'(Done);
        end
        check("st_stall_quiet", 128'(wcount), 128'd0);
        check("st_stall_mem_untouched", 128'(mem[8'h30]), 128'h0);
        Run = 1'b1;
        #1;
        check("st_resume_w_done", {W, Done}, 128'b11);
        @(negedge Clock);
        Run = 1'b0;
        check("st_resume_mem", 128'(mem[8'h30]), 128'hBEEF);
        check("st_resume_w_low", 128'(W), 128'h0);
        $display("st stall seq: mem[30]=%h", mem[8'h30]);

        // Random memory images executed instruction by instruction.
        for (int p = 0; p < 2; p++) begin
            clear_prog();
            for (int i = 0; i < 256; i++) prog[i] = 16'($urandom);
            start();
            for (int k = 0; k < 80; k++) begin
                model_step(mc);
                run_instrs(1, cyc, dn, wn);
                check($sformatf("rand%0d_%0d_regs", p, k), dut_regs(), model_regs());
                check($sformatf("rand%0d_%0d_cycles", p, k), 128'(cyc), 128'(mc));
                $display("rand %0d.%0d: ir=%03h pc=%04h cycles=%0d", p, k, instrucao, PC, cyc);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
